clock_display: RTL
==================

# clock_display

Time-of-day counter and 6-digit multiplexed 7-segment driver, placed directly downstream of the timer block. It consumes the timer's single-cycle one-second tick and keeps hours:minutes:seconds in BCD with 24-hour wrap. It also scans the six digits of a common-anode display (active-low segments and digit enables) and exports the BCD time and a midnight rollover pulse.

## Interface
- SCAN_DIV, 50000: clk_50m cycles per digit slot; 50000 gives a 1 kHz digit rate. Legal range 2..2^20.
- clk_50m  in  1  system clock; all logic is single-clock, posedge.
- reset  in  1  synchronous, active-high reset.
- one_sec_tick  in  1  single-cycle pulse from the timer's one-second output; may be asserted on consecutive cycles.
- clear  in  1  synchronous clear of the time to 00:00:00; level-sensitive and held while high. The scan is not affected.
- hold  in  1  freeze time; ticks that arrive while hold is high are dropped, not queued.
- sec_bcd  out  8  seconds in BCD, {tens, units}, 0x00..0x59.
- min_bcd  out  8  minutes in BCD, 0x00..0x59.
- hour_bcd  out  8  hours in BCD, 0x00..0x23.
- rollover  out  1  one-cycle pulse on the 23:59:59 -> 00:00:00 wrap.
- seg_n  out  7  active-low segments; bit0 = a, bit6 = g.
- dp_n  out  1  active-low decimal point; lit (0) only while digit 2 or digit 4 is enabled.
- dig_n  out  6  active-low one-hot digit enables. Digit 0 = seconds units, digit 1 = seconds tens, digit 2 = minutes units, digit 3 = minutes tens, digit 4 = hours units, digit 5 = hours tens.

## Operation
- Time counter: six BCD nibbles. Per tick the update order is: seconds units 9->0 with carry, seconds tens 5->0 with carry, minutes units and tens the same way, then hours. Hours wrap 23 -> 00 using an explicit compare, not a per-nibble wrap. No nibble ever holds a value above 9.
- Update priority per cycle: reset > clear > hold > one_sec_tick.
  - clear with a tick in the same cycle: result is 00:00:00 and rollover is not pulsed.
  - hold with a tick in the same cycle: no change.
- rollover is high in the cycle after the tick that wraps 23:59:59 to 00:00:00. It is low in every other cycle.
- Scan counter: counts 0..SCAN_DIV-1. At the terminal count it wraps to 0 and the digit index advances 0->1->...->5->0. Only reset clears the counter and the index.
- Segment decode of the selected nibble, given as hex of seg_n:
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78, 8:00, 9:10.
  - No blanking of leading zeros.
- seg_n, dp_n and dig_n are registered together from the current index and the current time registers. They therefore never disagree about which digit is shown.

## Timing
- Reset values, holding for the whole reset cycle and the cycle after:
  - BCD outputs 0x00, rollover 0.
  - Scan counter 0, index 0.
  - dig_n 6'b111111, seg_n 7'h7F, dp_n 1 (display dark).
- In the first cycle after reset deasserts, the display outputs load from index 0: dig_n 6'b111110, seg_n 7'h40.
- Tick latency: a tick sampled at edge N is visible on the *_bcd outputs after edge N, i.e. 1 cycle. rollover follows the same timing.
- Display latency: a time change or index change appears on seg_n/dig_n one cycle after the corresponding register changes.
  - Each digit is enabled for exactly SCAN_DIV cycles.
  - A full frame is 6*SCAN_DIV cycles.
  - A time update in mid-slot changes seg_n mid-slot; this is allowed.
- Reset asserted mid-count aborts everything. No tick is remembered across reset.
- Back-to-back ticks: each tick cycle advances the time exactly one second.

## Test plan
- Reset: hold reset 3 cycles, then release. Required: *_bcd = 0x00, rollover = 0, dig_n = 111111 during reset and 111110 one cycle after release, seg_n = 0x40.
- Counting: 59 back-to-back ticks -> sec_bcd = 0x59, min_bcd = 0x00. One more tick -> sec_bcd = 0x00, min_bcd = 0x01 on the next cycle.
- Midnight: 86399 ticks -> 0x23/0x59/0x59 with rollover 0. One more tick -> all 0x00, rollover high for exactly 1 cycle.
- Priority: at 00:12:34, assert clear together with a tick -> 00:00:00 next cycle, rollover 0. Then hold = 1 with 10 ticks -> time unchanged. Then hold = 0 with 1 tick -> sec_bcd = 0x01.
- Scan (SCAN_DIV = 4) at 12:34:56:
  - dig_n steps 111110 -> 111101 -> ... -> 011111 -> 111110, one step every 4 cycles.
  - seg_n per digit: 0x02, 0x12, 0x19, 0x30, 0x24, 0x79.
  - dp_n = 0 only on dig_n 111011 and 101111.
- Reset mid-scan: assert reset while digit 3 is enabled -> next cycle dark, index restarts at digit 0, time = 00:00:00.

Source files
------------

// File: rtl/clock_display_if.sv
// clock_display_if: bundles the clock_display control inputs and its time and
// display outputs so that one port carries the whole block interface.
//   one_sec_tick : single-cycle pulse from the timer's one-second output
//   clear        : level-sensitive clear of the time to 00:00:00
//   hold         : freeze time; ticks that arrive while held are dropped
//   sec_bcd, min_bcd, hour_bcd : time of day in BCD {tens, units}
//   rollover     : one-cycle pulse on the 23:59:59 -> 00:00:00 wrap
//   seg_n, dp_n, dig_n : active-low common-anode display drive
// master drives the controls (timer/host side); slave is the clock_display.
interface clock_display_if;
  logic       one_sec_tick;
  logic       clear;
  logic       hold;
  logic [7:0] sec_bcd;
  logic [7:0] min_bcd;
  logic [7:0] hour_bcd;
  logic       rollover;
  logic [6:0] seg_n;
  logic       dp_n;
  logic [5:0] dig_n;

  modport master (
    output one_sec_tick, clear, hold,
    input  sec_bcd, min_bcd, hour_bcd, rollover, seg_n, dp_n, dig_n
  );

  modport slave (
    input  one_sec_tick, clear, hold,
    output sec_bcd, min_bcd, hour_bcd, rollover, seg_n, dp_n, dig_n
  );
endinterface

// File: rtl/clock_display.sv
// clock_display: BCD hours:minutes:seconds time-of-day counter with 24-hour
// wrap, driven by the timer's one-second tick, plus a 6-digit multiplexed
// common-anode 7-segment driver.
//   clk_50m : system clock, all logic on posedge
//   reset   : synchronous active-high reset
//   bus     : clock_display_if.slave (tick/clear/hold in; BCD time,
//             rollover pulse and display drive out)
// SCAN_DIV sets the clk_50m cycles each digit stays enabled (2..2^20).
module clock_display #(
  parameter int SCAN_DIV = 50000
) (
  input  logic clk_50m,
  input  logic reset,
  clock_display_if.slave bus
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [3:0] su_q, st_q, mu_q, mt_q, hu_q, ht_q;
  logic [3:0] su_d, st_d, mu_d, mt_d, hu_d, ht_d;
  logic       roll_q, roll_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [6:0] seg_q, seg_d;
  logic       dp_q, dp_d;
  logic [5:0] dig_q, dig_d;
  logic [3:0] nib;

  // Active-low segment pattern, bit0 = a ... bit6 = g. Non-BCD codes go dark.
  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'd0:    seg_decode = 7'h40;
      4'd1:    seg_decode = 7'h79;
      4'd2:    seg_decode = 7'h24;
      4'd3:    seg_decode = 7'h30;
      4'd4:    seg_decode = 7'h19;
      4'd5:    seg_decode = 7'h12;
      4'd6:    seg_decode = 7'h02;
      4'd7:    seg_decode = 7'h78;
      4'd8:    seg_decode = 7'h00;
      4'd9:    seg_decode = 7'h10;
      default: seg_decode = 7'h7F;
    endcase
  endfunction

  // Time update: clear beats hold, hold beats tick. The carry ripples from
  // seconds units upward; hours wrap on an explicit 23 compare.
  always_comb begin
    su_d   = su_q;
    st_d   = st_q;
    mu_d   = mu_q;
    mt_d   = mt_q;
    hu_d   = hu_q;
    ht_d   = ht_q;
    roll_d = 1'b0;
    if (bus.clear) begin
      su_d = 4'd0;
      st_d = 4'd0;
      mu_d = 4'd0;
      mt_d = 4'd0;
      hu_d = 4'd0;
      ht_d = 4'd0;
    end else if (!bus.hold && bus.one_sec_tick) begin
      if (su_q != 4'd9) begin
        su_d = su_q + 4'd1;
      end else begin
        su_d = 4'd0;
        if (st_q != 4'd5) begin
          st_d = st_q + 4'd1;
        end else begin
          st_d = 4'd0;
          if (mu_q != 4'd9) begin
            mu_d = mu_q + 4'd1;
          end else begin
            mu_d = 4'd0;
            if (mt_q != 4'd5) begin
              mt_d = mt_q + 4'd1;
            end else begin
              mt_d = 4'd0;
              if (ht_q == 4'd2 && hu_q == 4'd3) begin
                ht_d   = 4'd0;
                hu_d   = 4'd0;
                roll_d = 1'b1;
              end else if (hu_q == 4'd9) begin
                hu_d = 4'd0;
                ht_d = ht_q + 4'd1;
              end else begin
                hu_d = hu_q + 4'd1;
              end
            end
          end
        end
      end
    end
  end

  // Scan: slot counter and digit index, free running; only reset touches them.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    end
  end

  // Display drive is built from the same index for segments, point and enable,
  // so all three always refer to the same digit.
  always_comb begin
    case (idx_q)
      3'd0:    nib = su_q;
      3'd1:    nib = st_q;
      3'd2:    nib = mu_q;
      3'd3:    nib = mt_q;
      3'd4:    nib = hu_q;
      default: nib = ht_q;
    endcase
    seg_d = seg_decode(nib);
    dig_d = ~(6'b000001 << idx_q);
    dp_d  = !(idx_q == 3'd2 || idx_q == 3'd4);
  end

  always_ff @(posedge clk_50m) begin
    if (reset) begin
      su_q   <= 4'd0;
      st_q   <= 4'd0;
      mu_q   <= 4'd0;
      mt_q   <= 4'd0;
      hu_q   <= 4'd0;
      ht_q   <= 4'd0;
      roll_q <= 1'b0;
      cnt_q  <= '0;
      idx_q  <= 3'd0;
      seg_q  <= 7'h7F;
      dp_q   <= 1'b1;
      dig_q  <= 6'h3F;
    end else begin
      su_q   <= su_d;
      st_q   <= st_d;
      mu_q   <= mu_d;
      mt_q   <= mt_d;
      hu_q   <= hu_d;
      ht_q   <= ht_d;
      roll_q <= roll_d;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      dig_q  <= dig_d;
    end
  end

  assign bus.sec_bcd  = {st_q, su_q};
  assign bus.min_bcd  = {mt_q, mu_q};
  assign bus.hour_bcd = {ht_q, hu_q};
  assign bus.rollover = roll_q;
  assign bus.seg_n    = seg_q;
  assign bus.dp_n     = dp_q;
  assign bus.dig_n    = dig_q;

endmodule
